// File: rtl/fpnew_result_buffer.sv
// Result buffer placed after the FPU output port. Buffers result/status/tag
// beats in a small FIFO so the FPU keeps draining while writeback stalls,
// and accrues the exception flags of results consumed by writeback.
module fpnew_result_buffer #(
  parameter int unsigned Width    = 16,
  parameter int unsigned Depth    = 4,
  parameter int unsigned TagWidth = 1,
  parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic [Width-1:0]    fpu_result_i,
  input  logic [4:0]          fpu_status_i,
  input  logic [TagWidth-1:0] fpu_tag_i,
  input  logic                fpu_valid_i,
  output logic                fpu_ready_o,
  output logic [Width-1:0]    result_o,
  output logic [4:0]          status_o,
  output logic [TagWidth-1:0] tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [4:0]          fflags_o,
  input  logic                fflags_clr_i,
  output logic [CntWidth-1:0] count_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]    res_mem [Depth];
  logic [4:0]          sts_mem [Depth];
  logic [TagWidth-1:0] tag_mem [Depth];

  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q;
  logic [4:0]          fflags_q;
  logic                push, pop;

  // Status decode and handshakes; ready depends on occupancy only
  always_comb begin
    full_o      = (count_q == CntWidth'(Depth));
    empty_o     = (count_q == '0);
    fpu_ready_o = !full_o;
    out_valid_o = !empty_o;
    push        = fpu_valid_i & fpu_ready_o;
    pop         = out_valid_o & out_ready_i;
    result_o    = res_mem[rd_ptr_q];
    status_o    = sts_mem[rd_ptr_q];
    tag_o       = tag_mem[rd_ptr_q];
    count_o     = count_q;
    fflags_o    = fflags_q;
  end

  // Entry storage; a beat pushed in a flush cycle is discarded
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        res_mem[i] <= '0;
        sts_mem[i] <= '0;
        tag_mem[i] <= '0;
      end
    end else if (push && !flush_i) begin
      res_mem[wr_ptr_q] <= fpu_result_i;
      sts_mem[wr_ptr_q] <= fpu_status_i;
      tag_mem[wr_ptr_q] <= fpu_tag_i;
    end
  end

  // Pointers and occupancy; flush overrides push and pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      if (push && !pop)      count_q <= count_q + CntWidth'(1);
      else if (pop && !push) count_q <= count_q - CntWidth'(1);
    end
  end

  // Sticky flags: clear takes effect before accruing the popped status;
  // a pop in a flush cycle is not recorded
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fflags_q <= '0;
    end else if (pop && !flush_i) begin
      fflags_q <= (fflags_clr_i ? 5'b0 : fflags_q) | status_o;
    end else if (fflags_clr_i) begin
      fflags_q <= '0;
    end
  end

endmodule

// File: tb/tb_fpnew_result_buffer.sv
// Self-checking bench for fpnew_result_buffer: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_fpnew_result_buffer;

  logic        clk_i, rst_ni, flush_i;
  logic [15:0] fpu_result_i;
  logic [4:0]  fpu_status_i;
  logic [0:0]  fpu_tag_i;
  logic        fpu_valid_i, fpu_ready_o;
  logic [15:0] result_o;
  logic [4:0]  status_o;
  logic [0:0]  tag_o;
  logic        out_valid_o, out_ready_i;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i;
  logic [2:0]  count_o;
  logic        full_o, empty_o;

  int checks = 0;
  int failures = 0;

  // reference model: FIFO contents and sticky flags
  logic [15:0] rq[$];
  logic [4:0]  sq[$];
  logic [0:0]  tq[$];
  logic [4:0]  m_ff;

  fpnew_result_buffer #(.Width(16), .Depth(4), .TagWidth(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
    .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
    .result_o(result_o), .status_o(status_o), .tag_o(tag_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Drives one cycle from a negedge, advances the model at the posedge,
  // and returns at the next negedge.
  task automatic drive_edge(input bit v, input logic [15:0] r, input logic [4:0] s,
                            input logic [0:0] t, input bit rdy, input bit clr, input bit fl);
    bit do_push, do_pop;
    fpu_valid_i = v; fpu_result_i = r; fpu_status_i = s; fpu_tag_i = t;
    out_ready_i = rdy; fflags_clr_i = clr; flush_i = fl;
    do_push = v && (rq.size() < 4);
    do_pop  = rdy && (rq.size() > 0);
    @(posedge clk_i);
    if (fl) begin
      if (clr) m_ff = 5'b0;
      rq.delete(); sq.delete(); tq.delete();
    end else begin
      if (do_pop) begin
        m_ff = (clr ? 5'b0 : m_ff) | sq[0];
        void'(rq.pop_front()); void'(sq.pop_front()); void'(tq.pop_front());
      end else if (clr) m_ff = 5'b0;
      if (do_push) begin rq.push_back(r); sq.push_back(s); tq.push_back(t); end
    end
    @(negedge clk_i);
    fpu_valid_i = 0; out_ready_i = 0; fflags_clr_i = 0; flush_i = 0;
  endtask

  task automatic test_reset();
    rst_ni = 0; flush_i = 0; fpu_valid_i = 0; out_ready_i = 0; fflags_clr_i = 0;
    fpu_result_i = '0; fpu_status_i = '0; fpu_tag_i = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    rq.delete(); sq.delete(); tq.delete(); m_ff = 5'b0;
    @(negedge clk_i);
    checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin failures++; $display("FAIL reset_flags empty=%0b full=%0b exp empty=1 full=0", empty_o, full_o); end
    checks++; if (fpu_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_hs ready=%0b valid=%0b exp 1/0", fpu_ready_o, out_valid_o); end
    checks++; if (fflags_o !== 5'b0) begin failures++; $display("FAIL reset_fflags got=%b exp=00000", fflags_o); end
    checks++; if (result_o !== 16'h0 || status_o !== 5'h0 || tag_o !== 1'b0) begin failures++; $display("FAIL reset_data got=%h/%b/%b exp 0", result_o, status_o, tag_o); end
  endtask

  task automatic test_single();
    drive_edge(1, 16'h3C00, 5'b00001, 1'b1, 0, 0, 0);
    checks++; if (out_valid_o !== 1'b1 || result_o !== 16'h3C00) begin failures++; $display("FAIL single_head valid=%0b res=%h exp 1/3c00", out_valid_o, result_o); end
    checks++; if (status_o !== 5'b00001 || tag_o !== 1'b1) begin failures++; $display("FAIL single_sts got=%b/%b exp 00001/1", status_o, tag_o); end
    checks++; if (count_o !== 3'd1 || fflags_o !== 5'b0) begin failures++; $display("FAIL single_cnt cnt=%0d ff=%b exp 1/00000", count_o, fflags_o); end
    drive_edge(0, 16'h0, 5'b0, 1'b0, 1, 0, 0);
    checks++; if (fflags_o !== 5'b00001 || empty_o !== 1'b1) begin failures++; $display("FAIL single_pop ff=%b empty=%0b exp 00001/1", fflags_o, empty_o); end
  endtask

  task automatic test_fill();
    logic [15:0] fifth;
    for (int i = 0; i < 4; i++)
      drive_edge(1, 16'($urandom), 5'($urandom), 1'($urandom), 0, 0, 0);
    checks++; if (full_o !== 1'b1 || fpu_ready_o !== 1'b0 || count_o !== 3'd4) begin failures++; $display("FAIL fill_full full=%0b ready=%0b cnt=%0d exp 1/0/4", full_o, fpu_ready_o, count_o); end
    fifth = 16'hBEEF;
    drive_edge(1, fifth, 5'b00011, 1'b0, 0, 0, 0);
    checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL fill_hold cnt=%0d exp=4", count_o); end
    drive_edge(1, fifth, 5'b00011, 1'b0, 1, 0, 0);
    checks++; if (count_o !== 3'd3 || fpu_ready_o !== 1'b1) begin failures++; $display("FAIL fill_pop cnt=%0d ready=%0b exp 3/1", count_o, fpu_ready_o); end
    drive_edge(1, fifth, 5'b00011, 1'b0, 0, 0, 0);
    checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL fill_accept cnt=%0d exp=4", count_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (result_o !== rq[0] || status_o !== sq[0] || tag_o !== tq[0]) begin failures++; $display("FAIL fill_order%0d got=%h exp=%h", i, result_o, rq[0]); end
      drive_edge(0, 16'h0, 5'b0, 1'b0, 1, 0, 0);
    end
    checks++; if (empty_o !== 1'b1 || fflags_o !== m_ff) begin failures++; $display("FAIL fill_drain empty=%0b ff=%b exp 1/%b", empty_o, fflags_o, m_ff); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      drive_edge(1, 16'(i), 5'($urandom), 1'(i), 1, 0, 0);
      checks++; if (count_o !== 3'd1 || result_o !== 16'(i)) begin failures++; $display("FAIL stream%0d cnt=%0d res=%h exp 1/%h", i, count_o, result_o, 16'(i)); end
    end
    drive_edge(0, 16'h0, 5'b0, 1'b0, 1, 0, 0);
    checks++; if (empty_o !== 1'b1 || fflags_o !== m_ff) begin failures++; $display("FAIL stream_end empty=%0b ff=%b exp 1/%b", empty_o, fflags_o, m_ff); end
  endtask

  task automatic test_fflags();
    drive_edge(0, 16'h0, 5'b0, 1'b0, 0, 1, 0);
    checks++; if (fflags_o !== 5'b0) begin failures++; $display("FAIL ff_clr0 got=%b exp=00000", fflags_o); end
    drive_edge(1, 16'h1, 5'b10000, 1'b0, 0, 0, 0);
    drive_edge(1, 16'h2, 5'b00100, 1'b0, 0, 0, 0);
    drive_edge(1, 16'h3, 5'b00001, 1'b0, 0, 0, 0);
    checks++; if (fflags_o !== 5'b0) begin failures++; $display("FAIL ff_push got=%b exp=00000", fflags_o); end
    drive_edge(0, 16'h0, 5'b0, 1'b0, 1, 0, 0);
    drive_edge(0, 16'h0, 5'b0, 1'b0, 1, 0, 0);
    checks++; if (fflags_o !== 5'b10100) begin failures++; $display("FAIL ff_accrue got=%b exp=10100", fflags_o); end
    drive_edge(0, 16'h0, 5'b0, 1'b0, 1, 1, 0);
    checks++; if (fflags_o !== 5'b00001) begin failures++; $display("FAIL ff_clrpop got=%b exp=00001", fflags_o); end
    drive_edge(0, 16'h0, 5'b0, 1'b0, 0, 1, 0);
    checks++; if (fflags_o !== 5'b0) begin failures++; $display("FAIL ff_clr got=%b exp=00000", fflags_o); end
  endtask

  task automatic test_flush();
    drive_edge(1, 16'h10, 5'b01000, 1'b0, 0, 0, 0);
    drive_edge(1, 16'h11, 5'b00010, 1'b0, 1, 0, 0);
    drive_edge(1, 16'h12, 5'b00100, 1'b1, 0, 0, 0);
    drive_edge(1, 16'h13, 5'b00001, 1'b0, 0, 0, 0);
    checks++; if (count_o !== 3'd3 || fflags_o !== 5'b01000) begin failures++; $display("FAIL flush_pre cnt=%0d ff=%b exp 3/01000", count_o, fflags_o); end
    drive_edge(1, 16'h14, 5'b10000, 1'b0, 1, 0, 1);
    checks++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin failures++; $display("FAIL flush_cnt cnt=%0d valid=%0b exp 0/0", count_o, out_valid_o); end
    checks++; if (fflags_o !== 5'b01000 || fpu_ready_o !== 1'b1) begin failures++; $display("FAIL flush_ff ff=%b ready=%0b exp 01000/1", fflags_o, fpu_ready_o); end
  endtask

  task automatic test_async_reset();
    drive_edge(1, 16'h20, 5'b00010, 1'b0, 0, 1, 0);
    drive_edge(1, 16'h21, 5'b00001, 1'b1, 1, 0, 0);
    drive_edge(1, 16'h22, 5'b00100, 1'b0, 0, 0, 0);
    checks++; if (count_o !== 3'd2 || fflags_o !== 5'b00010) begin failures++; $display("FAIL areset_pre cnt=%0d ff=%b exp 2/00010", count_o, fflags_o); end
    #2 rst_ni = 0;
    #1;
    checks++; if (count_o !== 3'd0 || empty_o !== 1'b1 || out_valid_o !== 1'b0) begin failures++; $display("FAIL areset_cnt cnt=%0d empty=%0b valid=%0b exp 0/1/0", count_o, empty_o, out_valid_o); end
    checks++; if (fflags_o !== 5'b0 || fpu_ready_o !== 1'b1 || result_o !== 16'h0) begin failures++; $display("FAIL areset_out ff=%b ready=%0b res=%h exp 0/1/0", fflags_o, fpu_ready_o, result_o); end
    @(negedge clk_i);
    rst_ni = 1;
    rq.delete(); sq.delete(); tq.delete(); m_ff = 5'b0;
    @(negedge clk_i);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      checks++; if (fpu_ready_o !== (rq.size() < 4)) begin failures++; $display("FAIL rnd_ready%0d got=%0b exp=%0b", i, fpu_ready_o, rq.size() < 4); end
      drive_edge($urandom_range(0, 3) != 0, 16'($urandom), 5'($urandom), 1'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0);
      checks++; if (count_o !== 3'(rq.size()) || out_valid_o !== (rq.size() > 0)) begin failures++; $display("FAIL rnd_cnt%0d cnt=%0d valid=%0b exp=%0d", i, count_o, out_valid_o, rq.size()); end
      checks++; if (fflags_o !== m_ff) begin failures++; $display("FAIL rnd_ff%0d got=%b exp=%b", i, fflags_o, m_ff); end
      if (rq.size() > 0) begin
        checks++; if (result_o !== rq[0] || status_o !== sq[0] || tag_o !== tq[0]) begin failures++; $display("FAIL rnd_head%0d got=%h/%b/%b exp=%h/%b/%b", i, result_o, status_o, tag_o, rq[0], sq[0], tq[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_fflags();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
